// File: rtl/lfsr_interval_timer.sv
// rtl/lfsr_interval_timer.sv - XNOR-feedback LFSR interval timer with one-shot/periodic modes
//
// Purpose
//   The LFSR advances on qualified ticks (tick_en) while the timer runs. When the
//   registered LFSR value equals the terminal pattern latched at start, the timer
//   emits a registered one-cycle timeout pulse. It then reloads SEED and either
//   returns to IDLE (one-shot) or keeps running (periodic).
//
// Optional feature
//   LFSR_TIMER_TOCOUNT_EN : adds the CNT_W parameter and the timeout_count output,
//                           a saturating count of timeout pulses.
//
// Parameters
//   WIDTH  LFSR width in bits (>= 3)
//   TAPS   feedback tap mask, bit i set = lfsr[i] tapped
//   SEED   reload value; must not be all-ones (XNOR lock-up state)
//   CNT_W  width of timeout_count (LFSR_TIMER_TOCOUNT_EN only)
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high
//   start          in   arm/restart timer
//   stop           in   abort timer, return to IDLE
//   mode_periodic  in   1 = auto-reload after timeout, latched on start
//   term_value     in   terminal LFSR pattern, latched on start
//   tick_en        in   LFSR steps only when 1
//   busy           out  1 while in RUN
//   timeout        out  registered 1-cycle pulse on terminal match
//   lfsr_state     out  current LFSR value
//   timeout_count  out  saturating timeout count (LFSR_TIMER_TOCOUNT_EN only)

module lfsr_interval_timer #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 16'h8016,
  parameter logic [WIDTH-1:0] SEED  = '0
`ifdef LFSR_TIMER_TOCOUNT_EN
  , parameter int             CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mode_periodic,
  input  logic [WIDTH-1:0] term_value,
  input  logic             tick_en,
  output logic             busy,
  output logic             timeout,
  output logic [WIDTH-1:0] lfsr_state
`ifdef LFSR_TIMER_TOCOUNT_EN
  , output logic [CNT_W-1:0] timeout_count
`endif
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             mode_q, mode_d;
  logic             timeout_q, timeout_d;
  logic             start_from_idle;

  // XNOR feedback makes all-zeros a legal state, so a zero SEED works.
  // All-ones becomes the lock-up state instead.
  logic             feedback;
  logic [WIDTH-1:0] lfsr_next;

  assign feedback  = ~^(lfsr_q & TAPS);
  assign lfsr_next = {lfsr_q[WIDTH-2:0], feedback};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      term_q    <= '0;
      mode_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      term_q    <= term_d;
      mode_q    <= mode_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    lfsr_d          = lfsr_q;
    term_d          = term_q;
    mode_d          = mode_q;
    timeout_d       = 1'b0;
    start_from_idle = 1'b0;

    case (state_q)
      IDLE: begin
        // stop and tick_en have no effect here; the LFSR holds.
        if (start) begin
          lfsr_d          = SEED;
          term_d          = term_value;
          mode_d          = mode_periodic;
          state_d         = RUN;
          start_from_idle = 1'b1;
        end
      end

      RUN: begin
        if (stop) begin
          // stop beats both a simultaneous start and a pending match.
          state_d = IDLE;
          lfsr_d  = SEED;
        end else if (start) begin
          // A restart suppresses the pulse even on a match cycle.
          lfsr_d = SEED;
          term_d = term_value;
          mode_d = mode_periodic;
        end else if (lfsr_q == term_q) begin
          // The match is checked on the registered value, so it fires one cycle
          // after the terminal state is reached, whatever tick_en is doing.
          timeout_d = 1'b1;
          lfsr_d    = SEED;
          state_d   = mode_q ? RUN : IDLE;
        end else if (tick_en) begin
          lfsr_d = lfsr_next;
        end
      end

      default: begin
        state_d = IDLE;
        lfsr_d  = SEED;
      end
    endcase
  end

  assign busy       = (state_q == RUN);
  assign timeout    = timeout_q;
  assign lfsr_state = lfsr_q;

`ifdef LFSR_TIMER_TOCOUNT_EN
  logic [CNT_W-1:0] count_q;

  // Counts at the same edge that raises timeout, so the two appear together.
  // Only a fresh start from IDLE clears the count; a restart in RUN keeps it.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (start_from_idle) begin
      count_q <= '0;
    end else if (timeout_d && (count_q != {CNT_W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign timeout_count = count_q;
`endif

endmodule

// File: tb/tb_lfsr_interval_timer.sv
// tb/tb_lfsr_interval_timer.sv - directed self-checking bench for lfsr_interval_timer

module tb_lfsr_interval_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic        mode_periodic;
  logic [15:0] term_value;
  logic        tick_en;
  logic        busy;
  logic        timeout;
  logic [15:0] lfsr_state;
`ifdef LFSR_TIMER_TOCOUNT_EN
  logic [1:0]  timeout_count;
`endif

  int checks = 0;
  int errors = 0;

  // LFSR states after SEED=0 with TAPS=8016, XNOR feedback.
  logic [15:0] seq [0:4] = '{16'h0000, 16'h0001, 16'h0003, 16'h0006, 16'h000D};

  always #5 clk = ~clk;

  lfsr_interval_timer #(
    .WIDTH(16),
    .TAPS (16'h8016),
    .SEED (16'h0000)
`ifdef LFSR_TIMER_TOCOUNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stop         (stop),
    .mode_periodic(mode_periodic),
    .term_value   (term_value),
    .tick_en      (tick_en),
    .busy         (busy),
    .timeout      (timeout),
    .lfsr_state   (lfsr_state)
`ifdef LFSR_TIMER_TOCOUNT_EN
    , .timeout_count(timeout_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0; mode_periodic = 1'b0;
    term_value = 16'h0000; tick_en = 1'b0;
    step(); step();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got %b exp 0", timeout); end
    checks++; if (lfsr_state !== 16'h0000) begin errors++; $display("FAIL reset_lfsr got %h exp 0000", lfsr_state); end
`ifdef LFSR_TIMER_TOCOUNT_EN
    checks++; if (timeout_count !== 2'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", timeout_count); end
`endif
  endtask

  task automatic test_one_shot();
    term_value = 16'h000D; mode_periodic = 1'b0; tick_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (busy !== 1'b1 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL oneshot_armed busy %b lfsr %h exp 1 0000", busy, lfsr_state); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (lfsr_state !== seq[i] || timeout !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL oneshot_step%0d lfsr %h to %b busy %b exp %h 0 1", i, lfsr_state, timeout, busy, seq[i]); end
    end
    step();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL oneshot_pulse to %b busy %b lfsr %h exp 1 0 0000", timeout, busy, lfsr_state); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (timeout !== 1'b0 || busy !== 1'b0 || lfsr_state !== 16'h0000) begin
        errors++; $display("FAIL oneshot_after%0d to %b busy %b lfsr %h exp 0 0 0000", i, timeout, busy, lfsr_state); end
    end
  endtask

  task automatic test_periodic();
    term_value = 16'h000D; mode_periodic = 1'b1; tick_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    mode_periodic = 1'b0; term_value = 16'h0003;
    for (int p = 0; p < 4; p++) begin
      for (int i = 1; i <= 4; i++) begin
        step();
        checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
          errors++; $display("FAIL periodic_gap p%0d i%0d to %b busy %b exp 0 1", p, i, timeout, busy); end
      end
      step();
      checks++; if (timeout !== 1'b1 || busy !== 1'b1) begin
        errors++; $display("FAIL periodic_pulse p%0d to %b busy %b exp 1 1", p, timeout, busy); end
`ifdef LFSR_TIMER_TOCOUNT_EN
      checks++; if (timeout_count !== ((p < 3) ? 2'(p + 1) : 2'd3)) begin
        errors++; $display("FAIL periodic_count p%0d got %0d exp %0d", p, timeout_count, (p < 3) ? p + 1 : 3); end
`endif
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL periodic_stop busy %b to %b lfsr %h exp 0 0 0000", busy, timeout, lfsr_state); end
    for (int i = 0; i < 8; i++) begin
      step();
      checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL periodic_quiet%0d to %b busy %b exp 0 0", i, timeout, busy); end
    end
`ifdef LFSR_TIMER_TOCOUNT_EN
    term_value = 16'h000D; mode_periodic = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (timeout_count !== 2'd0) begin
      errors++; $display("FAIL count_clear got %0d exp 0", timeout_count); end
    stop = 1'b1; step(); stop = 1'b0;
`endif
  endtask

  task automatic test_gated_ticks();
    int idx;
    term_value = 16'h000D; mode_periodic = 1'b0; tick_en = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    idx = 0;
    for (int j = 1; j <= 12; j++) begin
      tick_en = (j % 3 == 0);
      if (tick_en) idx++;
      step();
      checks++; if (lfsr_state !== seq[idx] || timeout !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL gated_e%0d lfsr %h to %b busy %b exp %h 0 1", j, lfsr_state, timeout, busy, seq[idx]); end
    end
    tick_en = 1'b0;
    step();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL gated_pulse to %b busy %b exp 1 0", timeout, busy); end
    tick_en = 1'b1;
  endtask

  task automatic test_priority();
    term_value = 16'h000D; mode_periodic = 1'b0; tick_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL prio_startstop busy %b to %b lfsr %h exp 0 0 0000", busy, timeout, lfsr_state); end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL prio_idle%0d to %b busy %b exp 0 0", i, timeout, busy); end
    end

    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    checks++; if (lfsr_state !== 16'h000D) begin
      errors++; $display("FAIL prio_at_term lfsr %h exp 000d", lfsr_state); end
    start = 1'b1; step(); start = 1'b0;
    checks++; if (timeout !== 1'b0 || busy !== 1'b1 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL prio_restart to %b busy %b lfsr %h exp 0 1 0000", timeout, busy, lfsr_state); end
    for (int i = 1; i <= 4; i++) begin
      step();
      checks++; if (timeout !== 1'b0) begin
        errors++; $display("FAIL prio_regap%0d to %b exp 0", i, timeout); end
    end
    step();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL prio_repulse to %b busy %b exp 1 0", timeout, busy); end

    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (timeout !== 1'b0 || busy !== 1'b0 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL prio_stop_match to %b busy %b lfsr %h exp 0 0 0000", timeout, busy, lfsr_state); end
  endtask

  task automatic test_boundaries();
    term_value = 16'h0000; mode_periodic = 1'b0; tick_en = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL seed_term_armed to %b busy %b exp 0 1", timeout, busy); end
    step();
    checks++; if (timeout !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL seed_term_pulse to %b busy %b exp 1 0", timeout, busy); end

    term_value = 16'h000D;
    start = 1'b1; step(); start = 1'b0;
    step(); step();
    checks++; if (lfsr_state !== 16'h0003) begin
      errors++; $display("FAIL reset_mid_pre lfsr %h exp 0003", lfsr_state); end
    reset = 1'b1; step(); reset = 1'b0;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0 || lfsr_state !== 16'h0000) begin
      errors++; $display("FAIL reset_mid busy %b to %b lfsr %h exp 0 0 0000", busy, timeout, lfsr_state); end
    step();
    checks++; if (timeout !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_after to %b busy %b exp 0 0", timeout, busy); end

    term_value = 16'hFFFF;
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL unreachable%0d to %b busy %b exp 0 1", i, timeout, busy); end
    end
    stop = 1'b1; step(); stop = 1'b0;
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL unreachable_stop busy %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_gated_ticks();
    test_priority();
    test_boundaries();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
